rle_dec: RTL

RLE_DEC -- requirements
Module: rle_dec

---
 rtl/rle_dec_pkg.sv | 18 +
 rtl/rle_dec_zigzag_rom.sv | 32 +++
 rtl/rle_dec.sv | 124 ++++++++++++
 3 files changed

// File: rtl/rle_dec_pkg.sv
// Shared definitions for the run-length decoder and its zigzag address map.
package rle_dec_pkg;

  localparam int BLOCK_SIZE = 64;
  localparam int COEF_W     = 16;
  localparam int ADDR_W     = 6;
  localparam int POS_W      = 7;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DC,
    WAIT_TOK,
    RUN,
    WRITE,
    FILL
  } state_t;

endpackage

// File: rtl/rle_dec_zigzag_rom.sv
// Combinational zigzag scan map: scan position k -> raster address of an 8x8 block.
module zigzag_rom
  import rle_dec_pkg::*;
(
  input  logic [ADDR_W-1:0] k,
  output logic [ADDR_W-1:0] a
);

  always_comb begin
    a = '0;
    case (k)
      6'd0:  a = 6'd0;   6'd1:  a = 6'd1;   6'd2:  a = 6'd8;   6'd3:  a = 6'd16;
      6'd4:  a = 6'd9;   6'd5:  a = 6'd2;   6'd6:  a = 6'd3;   6'd7:  a = 6'd10;
      6'd8:  a = 6'd17;  6'd9:  a = 6'd24;  6'd10: a = 6'd32;  6'd11: a = 6'd25;
      6'd12: a = 6'd18;  6'd13: a = 6'd11;  6'd14: a = 6'd4;   6'd15: a = 6'd5;
      6'd16: a = 6'd12;  6'd17: a = 6'd19;  6'd18: a = 6'd26;  6'd19: a = 6'd33;
      6'd20: a = 6'd40;  6'd21: a = 6'd48;  6'd22: a = 6'd41;  6'd23: a = 6'd34;
      6'd24: a = 6'd27;  6'd25: a = 6'd20;  6'd26: a = 6'd13;  6'd27: a = 6'd6;
      6'd28: a = 6'd7;   6'd29: a = 6'd14;  6'd30: a = 6'd21;  6'd31: a = 6'd28;
      6'd32: a = 6'd35;  6'd33: a = 6'd42;  6'd34: a = 6'd49;  6'd35: a = 6'd56;
      6'd36: a = 6'd57;  6'd37: a = 6'd50;  6'd38: a = 6'd43;  6'd39: a = 6'd36;
      6'd40: a = 6'd29;  6'd41: a = 6'd22;  6'd42: a = 6'd15;  6'd43: a = 6'd23;
      6'd44: a = 6'd30;  6'd45: a = 6'd37;  6'd46: a = 6'd44;  6'd47: a = 6'd51;
      6'd48: a = 6'd58;  6'd49: a = 6'd59;  6'd50: a = 6'd52;  6'd51: a = 6'd45;
      6'd52: a = 6'd38;  6'd53: a = 6'd31;  6'd54: a = 6'd39;  6'd55: a = 6'd46;
      6'd56: a = 6'd53;  6'd57: a = 6'd60;  6'd58: a = 6'd61;  6'd59: a = 6'd54;
      6'd60: a = 6'd47;  6'd61: a = 6'd55;  6'd62: a = 6'd62;  6'd63: a = 6'd63;
      default: a = '0;
    endcase
  end

endmodule

// File: rtl/rle_dec.sv
// Run-length token decoder: expands (run, value) tokens of one 8x8 block into
// 64 coefficient RAM writes, one word per clock, in scan order.
module rle_dec
  import rle_dec_pkg::*;
#(
  parameter int W      = COEF_W,
  parameter int ZIGZAG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic              rdy,
  output logic              s_rdy,
  input  logic              s_en,
  input  logic [W-1:0]      s_val,
  input  logic [5:0]        s_len,
  input  logic              s_end,
  input  logic              s_dc,
  output logic [ADDR_W-1:0] addr,
  output logic [W-1:0]      d,
  output logic              wren,
  output logic              err
);

  state_t           state;
  logic [POS_W-1:0] pos;
  logic [5:0]       run;
  logic [W-1:0]     val;
  logic             ovf;

  // Position 64 is one past the block; any write aimed there is dropped.
  assign ovf   = (pos >= POS_W'(BLOCK_SIZE));
  assign rdy   = (state == IDLE);
  assign s_rdy = (state == WAIT_DC) || (state == WAIT_TOK);

  if (ZIGZAG != 0) begin : g_zz
    zigzag_rom u_zz (
      .k(pos[ADDR_W-1:0]),
      .a(addr)
    );
  end else begin : g_lin
    assign addr = pos[ADDR_W-1:0];
  end

  // The DC word is written in its transfer cycle; every other word is written
  // from RUN/WRITE/FILL using the registered position and latched value.
  always_comb begin
    wren = 1'b0;
    d    = '0;
    case (state)
      WAIT_DC: begin
        wren = s_en;
        d    = s_end ? '0 : s_val;
      end
      RUN, FILL: wren = !ovf;
      WRITE: begin
        wren = !ovf;
        d    = val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      pos   <= '0;
      run   <= '0;
      val   <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            pos   <= '0;
            err   <= 1'b0;
            state <= WAIT_DC;
          end
        end
        WAIT_DC: begin
          if (s_en) begin
            if (s_end || !s_dc) err <= 1'b1;
            pos   <= POS_W'(1);
            state <= s_end ? FILL : WAIT_TOK;
          end
        end
        WAIT_TOK: begin
          if (s_en) begin
            if (s_end) begin
              state <= ovf ? IDLE : FILL;
            end else begin
              val <= s_val;
              run <= s_len;
              if (s_dc) err <= 1'b1;
              state <= (s_len != 6'd0) ? RUN : WRITE;
            end
          end
        end
        RUN: begin
          if (ovf) begin
            err   <= 1'b1;
            run   <= '0;
            state <= WAIT_TOK;
          end else begin
            pos <= pos + POS_W'(1);
            run <= run - 6'd1;
            if (run == 6'd1) state <= WRITE;
          end
        end
        WRITE: begin
          if (ovf) err <= 1'b1;
          else     pos <= pos + POS_W'(1);
          state <= WAIT_TOK;
        end
        FILL: begin
          pos <= pos + POS_W'(1);
          if (pos == POS_W'(BLOCK_SIZE - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
